// File: rtl/sysu_univ_shreg_if.sv
// sysu_univ_shreg_if: mode, serial, parallel and burst handshake signals of the universal shift register
interface sysu_univ_shreg_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       S;
   logic             DSA;
   logic             DSB;
   logic             DSR;
   logic [WIDTH-1:0] D;
   logic             START;
   logic [WIDTH-1:0] Q;
   logic             SO;
   logic             BUSY;
   logic             DONE;
   modport master (output S, DSA, DSB, DSR, D, START, input Q, SO, BUSY, DONE);
   modport slave  (input S, DSA, DSB, DSR, D, START, output Q, SO, BUSY, DONE);
endinterface

// File: rtl/sysu_univ_shreg.sv
// sysu_univ_shreg: universal shift register with hold/shift/load modes and a self-timed MSB-first burst serialiser
module sysu_univ_shreg #(
   parameter int WIDTH = 8
) (
   input logic              CP,
   input logic              MR_n,
   sysu_univ_shreg_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic {IDLE, BURST} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;
   logic             busy;
   logic             done;
   // shift candidates written as whole-word shifts so a 1-bit register needs no special case
   always_comb begin
      shl = (q << 1) | WIDTH'(bus.DSA & bus.DSB);
      shr = (q >> 1) | (WIDTH'(bus.DSR) << (WIDTH - 1));
   end
   // mode register and burst sequencer; a burst loads D then shifts left once per cycle for WIDTH cycles
   always_ff @(posedge CP or negedge MR_n) begin
      if (!MR_n) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (bus.START) begin
               q     <= bus.D;
               cnt   <= CNT_W'(WIDTH - 1);
               busy  <= 1'b1;
               state <= BURST;
            end else begin
               q <= (bus.S == 2'b01) ? shl : (bus.S == 2'b10) ? shr : (bus.S == 2'b11) ? bus.D : q;
            end
         end else begin
            q <= shl;
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
         end
      end
   end
   assign bus.Q    = q;
   assign bus.SO   = q[WIDTH-1];
   assign bus.BUSY = busy;
   assign bus.DONE = done;
endmodule
